control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state changes on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-003 SHALL have port run, input, 1, level; high permits fetch of the next instruction.
REQ-004 SHALL have port IR, input, 32, instruction register contents from datapath: opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15].
REQ-005 SHALL have ports Rout and Rin, output, 16 each, one-hot register out/in enables, bit n maps to Rn.
REQ-006 SHALL have ports PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin, Read, IncPC, output, 1 each, datapath strobes.
REQ-007 SHALL have port alu_op, output, 13, one-hot {AND,OR,ADD,SUB,MUL,DIV,SHR,SHRA,SHL,ROR,ROL,NEG,NOT}, bit 12 = AND.
REQ-008 SHALL have ports done and illegal, output, 1 each, one-cycle pulses.
REQ-009 SHALL have port instr_count, output, 16, count of completed instructions.

Function
REQ-010 SHALL be a Moore FSM with states IDLE, T0, T1, T2, T3, T4, T5, T6, DONE; all strobes SHALL be decoded from the state register and IR only.
REQ-011 SHALL deassert all strobes in IDLE; IDLE->T0 when run=1.
REQ-012 T0: PCout, MARin, IncPC, Zin asserted; ->T1.
REQ-013 T1: Zlowout, PCin, Read, MDRin asserted; ->T2.
REQ-014 T2: MDRout, IRin asserted; ->T3; IR SHALL be treated as valid from T3 onward.
REQ-015 Opcode map: ADD 00011, SUB 00100, AND 00101, OR 00110, SHR 00111, SHRA 01000, SHL 01001, ROR 01010, ROL 01011, MUL 01111, DIV 10000, NEG 10001, NOT 10010; any other value is illegal.
REQ-016 T3, legal opcode: Rout[Rb], Yin asserted; ->T4. T3, illegal opcode: no strobes; ->DONE with illegal=1 during DONE; no register written.
REQ-017 T4: alu_op bit for opcode and Zin asserted; Rout[Rc] asserted, except NEG/NOT which SHALL assert Rout[Rb]; ->T5.
REQ-018 T5: Zlowout asserted; Rin[Ra] for all ops except MUL/DIV, which SHALL assert LOin instead; ->T6 for MUL/DIV, else ->DONE.
REQ-019 T6 (MUL/DIV only): Zhighout, HIin asserted; ->DONE.
REQ-020 DONE: done=1; instr_count increments by 1, wrapping 16'hFFFF->0 without flag; illegal instructions SHALL also count; ->T0 if run=1, else IDLE.
REQ-021 Deassertion of run mid-instruction SHALL NOT abort; the instruction completes and FSM returns to IDLE.
REQ-022 At most one bit of Rout and at most one of {Rout, PCout, Zlowout, Zhighout, MDRout} SHALL be asserted in any cycle.
REQ-023 Ra=Rb or Rb=Rc SHALL need no special handling.

Reset
REQ-024 reset=0 at a rising edge SHALL force state IDLE, instr_count=0, and all outputs 0 by the next cycle, including mid-instruction; a partially executed instruction is abandoned.
REQ-025 reset SHALL take priority over run and step.

Configuration
REQ-026 Macro CTRL_STEP_EN: when defined, input step (1 bit) SHALL be added and every state transition other than reset SHALL occur only in cycles with step=1, state and strobes holding otherwise; when undefined, no step port exists and the FSM advances every cycle as above.

Verification
REQ-027 reset low 2 cycles, run=0 -> all outputs 0, instr_count=0, FSM stays IDLE.
REQ-028 run=1, IR=32'h221B8000 (SUB R4,R3,R7) -> T3 Rout=16'h0008,Yin; T4 Rout=16'h0080, SUB, Zin; T5 Zlowout, Rin=16'h0010; done pulses 7 cycles after T0 entry; instr_count=1.
REQ-029 IR opcode MUL (32'h7A1B8000, Rb=3, Rc=7) -> T5 LOin with Rin=0, T6 Zhighout+HIin, done in cycle 8 from T0.
REQ-030 IR opcode 11111 -> T3 no strobes, next cycle done=1 and illegal=1, Rin never asserted, instr_count increments.
REQ-031 reset low during T4 -> next cycle all strobes 0, state IDLE, instr_count=0; preload instr_count to 16'hFFFF and complete one instruction -> wraps to 0.
REQ-032 CTRL_STEP_EN defined, step pulsed every 3rd cycle -> strobes hold between pulses; sequence identical to REQ-028 per step.

Source files
------------

// File: rtl/control_sequencer.sv
// Hardwired control sequencer for a single-bus datapath: fetch T0-T2, execute T3-T6, DONE.
// Optional build macro CTRL_STEP_EN adds a step input that gates every non-reset transition.
module control_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
`ifdef CTRL_STEP_EN
    input  logic        step,
`endif
    input  logic [31:0] IR,
    output logic [15:0] Rout,
    output logic [15:0] Rin,
    output logic        PCout,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        MDRout,
    output logic        MARin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        HIin,
    output logic        LOin,
    output logic        Read,
    output logic        IncPC,
    output logic [12:0] alu_op,
    output logic        done,
    output logic        illegal,
    output logic [15:0] instr_count
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned ALU_W = 13;

    // alu_op bit positions, AND in the MSB
    localparam int unsigned B_AND  = 12;
    localparam int unsigned B_OR   = 11;
    localparam int unsigned B_ADD  = 10;
    localparam int unsigned B_SUB  = 9;
    localparam int unsigned B_MUL  = 8;
    localparam int unsigned B_DIV  = 7;
    localparam int unsigned B_SHR  = 6;
    localparam int unsigned B_SHRA = 5;
    localparam int unsigned B_SHL  = 4;
    localparam int unsigned B_ROR  = 3;
    localparam int unsigned B_ROL  = 2;
    localparam int unsigned B_NEG  = 1;
    localparam int unsigned B_NOT  = 0;

    typedef enum logic [3:0] {
        IDLE, T0, T1, T2, T3, T4, T5, T6, DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   instr_count_q, instr_count_d;

    logic [4:0]         opcode;
    logic [3:0]         ra, rb, rc;
    logic [ALU_W-1:0]   alu_sel;
    logic               legal, is_muldiv, is_unary;
    logic               advance;
    logic               unused_ir;

    assign opcode    = IR[31:27];
    assign ra        = IR[26:23];
    assign rb        = IR[22:19];
    assign rc        = IR[18:15];
    assign unused_ir = ^IR[14:0];

`ifdef CTRL_STEP_EN
    assign advance = step;
`else
    assign advance = 1'b1;
`endif

    assign instr_count = instr_count_q;

    function automatic logic [15:0] onehot16(input logic [3:0] idx);
        logic [15:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

    // Opcode decode into one-hot ALU select and class flags
    always_comb begin
        alu_sel   = '0;
        legal     = 1'b1;
        is_muldiv = 1'b0;
        is_unary  = 1'b0;
        case (opcode)
            5'b00011: alu_sel[B_ADD]  = 1'b1;
            5'b00100: alu_sel[B_SUB]  = 1'b1;
            5'b00101: alu_sel[B_AND]  = 1'b1;
            5'b00110: alu_sel[B_OR]   = 1'b1;
            5'b00111: alu_sel[B_SHR]  = 1'b1;
            5'b01000: alu_sel[B_SHRA] = 1'b1;
            5'b01001: alu_sel[B_SHL]  = 1'b1;
            5'b01010: alu_sel[B_ROR]  = 1'b1;
            5'b01011: alu_sel[B_ROL]  = 1'b1;
            5'b01111: begin alu_sel[B_MUL] = 1'b1; is_muldiv = 1'b1; end
            5'b10000: begin alu_sel[B_DIV] = 1'b1; is_muldiv = 1'b1; end
            5'b10001: begin alu_sel[B_NEG] = 1'b1; is_unary  = 1'b1; end
            5'b10010: begin alu_sel[B_NOT] = 1'b1; is_unary  = 1'b1; end
            default:  legal = 1'b0;
        endcase
    end

    // Next state, instruction counter and Moore strobe decode
    always_comb begin
        state_d       = state_q;
        instr_count_d = instr_count_q;
        Rout     = '0;
        Rin      = '0;
        PCout    = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        MDRout   = 1'b0;
        MARin    = 1'b0;
        PCin     = 1'b0;
        MDRin    = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        Read     = 1'b0;
        IncPC    = 1'b0;
        alu_op   = '0;
        done     = 1'b0;
        illegal  = 1'b0;

        case (state_q)
            IDLE: begin
                if (run) state_d = T0;
            end
            T0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                Zin     = 1'b1;
                state_d = T1;
            end
            T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                state_d = T2;
            end
            T2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = T3;
            end
            T3: begin
                if (legal) begin
                    Rout    = onehot16(rb);
                    Yin     = 1'b1;
                    state_d = T4;
                end else begin
                    state_d = DONE;
                end
            end
            T4: begin
                alu_op  = alu_sel;
                Zin     = 1'b1;
                Rout    = is_unary ? onehot16(rb) : onehot16(rc);
                state_d = T5;
            end
            T5: begin
                Zlowout = 1'b1;
                if (is_muldiv) begin
                    LOin    = 1'b1;
                    state_d = T6;
                end else begin
                    Rin     = onehot16(ra);
                    state_d = DONE;
                end
            end
            T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                done          = 1'b1;
                illegal       = ~legal;
                instr_count_d = instr_count_q + CNT_W'(1);
                state_d       = run ? T0 : IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Without a step the FSM and counter hold; strobes follow the held state
        if (!advance) begin
            state_d       = state_q;
            instr_count_d = instr_count_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            instr_count_q <= instr_count_d;
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-cycle strobe snapshots against hand-computed values.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [31:0] IR;
    logic [15:0] Rout, Rin;
    logic        PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin, IRin;
    logic        Yin, Zin, HIin, LOin, Read, IncPC;
    logic [12:0] alu_op;
    logic        done, illegal;
    logic [15:0] instr_count;
`ifdef CTRL_STEP_EN
    logic        step;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
`ifdef CTRL_STEP_EN
        .step       (step),
`endif
        .IR         (IR),
        .Rout       (Rout),
        .Rin        (Rin),
        .PCout      (PCout),
        .Zlowout    (Zlowout),
        .Zhighout   (Zhighout),
        .MDRout     (MDRout),
        .MARin      (MARin),
        .PCin       (PCin),
        .MDRin      (MDRin),
        .IRin       (IRin),
        .Yin        (Yin),
        .Zin        (Zin),
        .HIin       (HIin),
        .LOin       (LOin),
        .Read       (Read),
        .IncPC      (IncPC),
        .alu_op     (alu_op),
        .done       (done),
        .illegal    (illegal),
        .instr_count(instr_count)
    );

    localparam logic [13:0] S_PCOUT  = 14'h2000;
    localparam logic [13:0] S_ZLOW   = 14'h1000;
    localparam logic [13:0] S_ZHIGH  = 14'h0800;
    localparam logic [13:0] S_MDROUT = 14'h0400;
    localparam logic [13:0] S_MARIN  = 14'h0200;
    localparam logic [13:0] S_PCIN   = 14'h0100;
    localparam logic [13:0] S_MDRIN  = 14'h0080;
    localparam logic [13:0] S_IRIN   = 14'h0040;
    localparam logic [13:0] S_YIN    = 14'h0020;
    localparam logic [13:0] S_ZIN    = 14'h0010;
    localparam logic [13:0] S_HIIN   = 14'h0008;
    localparam logic [13:0] S_LOIN   = 14'h0004;
    localparam logic [13:0] S_READ   = 14'h0002;
    localparam logic [13:0] S_INCPC  = 14'h0001;

    localparam logic [12:0] A_ADD = 13'h0400;
    localparam logic [12:0] A_SUB = 13'h0200;
    localparam logic [12:0] A_MUL = 13'h0100;
    localparam logic [12:0] A_NEG = 13'h0002;

    localparam logic [31:0] IR_SUB = 32'h221B8000;  // SUB R4,R3,R7
    localparam logic [31:0] IR_MUL = 32'h7A1B8000;  // MUL Rb=3,Rc=7
    localparam logic [31:0] IR_ILL = 32'hF8000000;  // opcode 11111
    localparam logic [31:0] IR_NEG = 32'h8AAC8000;  // NEG R5,R5 (Rc=9 ignored)
    localparam logic [31:0] IR_ADD = 32'h18918000;  // ADD R1,R2,R3

    logic [13:0] sb;
    logic [60:0] obs;
    assign sb  = {PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin, IRin,
                  Yin, Zin, HIin, LOin, Read, IncPC};
    assign obs = {sb, Rout, Rin, alu_op, done, illegal};

    function automatic logic [60:0] snap(input logic [13:0] s, input logic [15:0] ro,
                                         input logic [15:0] ri, input logic [12:0] a,
                                         input logic d, input logic il);
        return {s, ro, ri, a, d, il};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_snap(input string tag, input logic [60:0] exp);
        check(tag, 64'(obs), 64'(exp));
    endtask

    logic [60:0] f0, f1, f2, zero_s;
    logic [60:0] sub_exp [7];

    initial begin
        zero_s = '0;
        f0 = snap(S_PCOUT | S_MARIN | S_INCPC | S_ZIN, 16'h0, 16'h0, 13'h0, 1'b0, 1'b0);
        f1 = snap(S_ZLOW | S_PCIN | S_READ | S_MDRIN, 16'h0, 16'h0, 13'h0, 1'b0, 1'b0);
        f2 = snap(S_MDROUT | S_IRIN, 16'h0, 16'h0, 13'h0, 1'b0, 1'b0);
        sub_exp[0] = f0;
        sub_exp[1] = f1;
        sub_exp[2] = f2;
        sub_exp[3] = snap(S_YIN, 16'h0008, 16'h0, 13'h0, 1'b0, 1'b0);
        sub_exp[4] = snap(S_ZIN, 16'h0080, 16'h0, A_SUB, 1'b0, 1'b0);
        sub_exp[5] = snap(S_ZLOW, 16'h0, 16'h0010, 13'h0, 1'b0, 1'b0);
        sub_exp[6] = snap(14'h0, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0);

`ifdef CTRL_STEP_EN
        step = 1'b1;
`endif
        reset = 1'b0;
        run   = 1'b0;
        IR    = 32'h0;
        tick();
        tick();
        expect_snap("reset_outputs", zero_s);
        check("reset_count", 64'(instr_count), 64'h0);
        reset = 1'b1;
        tick();
        tick();
        expect_snap("idle_run0", zero_s);

        // SUB, run dropped during T1 so the FSM parks in IDLE afterwards
        IR  = IR_SUB;
        run = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            if (k == 1) run = 1'b0;
            expect_snap($sformatf("sub_t%0d", k), sub_exp[k]);
        end
        tick();
        expect_snap("sub_after_idle", zero_s);
        check("sub_count", 64'(instr_count), 64'h1);

        // MUL then illegal back-to-back with run held high
        IR  = IR_MUL;
        run = 1'b1;
        tick(); expect_snap("mul_t0", f0);
        tick(); expect_snap("mul_t1", f1);
        tick(); expect_snap("mul_t2", f2);
        tick(); expect_snap("mul_t3", snap(S_YIN, 16'h0008, 16'h0, 13'h0, 1'b0, 1'b0));
        tick(); expect_snap("mul_t4", snap(S_ZIN, 16'h0080, 16'h0, A_MUL, 1'b0, 1'b0));
        tick(); expect_snap("mul_t5", snap(S_ZLOW | S_LOIN, 16'h0, 16'h0, 13'h0, 1'b0, 1'b0));
        tick(); expect_snap("mul_t6", snap(S_ZHIGH | S_HIIN, 16'h0, 16'h0, 13'h0, 1'b0, 1'b0));
        tick(); expect_snap("mul_done", snap(14'h0, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0));
        tick(); expect_snap("ill_t0", f0);
        check("mul_count", 64'(instr_count), 64'h2);
        IR  = IR_ILL;
        run = 1'b0;
        tick(); expect_snap("ill_t1", f1);
        tick(); expect_snap("ill_t2", f2);
        tick(); expect_snap("ill_t3", zero_s);
        tick(); expect_snap("ill_done", snap(14'h0, 16'h0, 16'h0, 13'h0, 1'b1, 1'b1));
        tick(); expect_snap("ill_idle", zero_s);
        check("ill_count", 64'(instr_count), 64'h3);

        // NEG with Ra=Rb: T4 reads Rb, not Rc
        IR  = IR_NEG;
        run = 1'b1;
        tick(); expect_snap("neg_t0", f0);
        run = 1'b0;
        tick(); expect_snap("neg_t1", f1);
        tick(); expect_snap("neg_t2", f2);
        tick(); expect_snap("neg_t3", snap(S_YIN, 16'h0020, 16'h0, 13'h0, 1'b0, 1'b0));
        tick(); expect_snap("neg_t4", snap(S_ZIN, 16'h0020, 16'h0, A_NEG, 1'b0, 1'b0));
        tick(); expect_snap("neg_t5", snap(S_ZLOW, 16'h0, 16'h0020, 13'h0, 1'b0, 1'b0));
        tick(); expect_snap("neg_done", snap(14'h0, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0));
        tick(); check("neg_count", 64'(instr_count), 64'h4);

        // Reset asserted during T4 abandons the instruction
        IR  = IR_ADD;
        run = 1'b1;
        tick(); tick(); tick(); tick();
        tick(); expect_snap("add_t4", snap(S_ZIN, 16'h0008, 16'h0, A_ADD, 1'b0, 1'b0));
        reset = 1'b0;
        tick(); expect_snap("rst_mid_outputs", zero_s);
        check("rst_mid_count", 64'(instr_count), 64'h0);
        reset = 1'b1;
        run   = 1'b0;
        tick(); expect_snap("rst_mid_idle", zero_s);

        // Counter wrap from 16'hFFFF
        force dut.instr_count_q = 16'hFFFF;
        tick(); tick();
        release dut.instr_count_q;
        tick();
        check("preload_count", 64'(instr_count), 64'hFFFF);
        IR  = IR_ADD;
        run = 1'b1;
        tick();
        run = 1'b0;
        tick(); tick(); tick(); tick(); tick();
        tick(); expect_snap("wrap_done", snap(14'h0, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0));
        tick(); check("wrap_count", 64'(instr_count), 64'h0);
        expect_snap("wrap_idle", zero_s);

`ifdef CTRL_STEP_EN
        // Step every third cycle: each state's strobes hold for three samples
        IR   = IR_SUB;
        run  = 1'b1;
        step = 1'b1;
        tick();
        for (int k = 0; k < 7; k++) begin
            step = 1'b0;
            if (k == 1) run = 1'b0;
            expect_snap($sformatf("step_s%0d_a", k), sub_exp[k]);
            tick();
            expect_snap($sformatf("step_s%0d_b", k), sub_exp[k]);
            tick();
            expect_snap($sformatf("step_s%0d_c", k), sub_exp[k]);
            step = 1'b1;
            tick();
        end
        step = 1'b0;
        expect_snap("step_idle", zero_s);
        check("step_count", 64'(instr_count), 64'h1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
